// File: rtl/fifo_dc_sync_if.sv
// fifo_dc_sync_if: handshake bundle between a producer/consumer and the
// single-clock FIFO.
//   we, wd  : write request and write data
//   re      : read request
//   rd      : registered read data
//   rvalid  : rd carries the word popped by the previous accepted read
//   wfull   : FIFO full (writes ignored)
//   rempty  : FIFO empty (reads ignored)
//   usedw   : occupancy, 0..2^N
//   ovf/unf : one-cycle pulses for a rejected write / rejected read
// The master modport is the user side and the slave modport is the FIFO side.
interface fifo_dc_sync_if #(
  parameter int W = 4,
  parameter int N = 2
);
  logic         we;
  logic [W-1:0] wd;
  logic         wfull;
  logic         re;
  logic [W-1:0] rd;
  logic         rvalid;
  logic         rempty;
  logic [N:0]   usedw;
  logic         ovf;
  logic         unf;

  modport master (
    output we, wd, re,
    input  wfull, rd, rvalid, rempty, usedw, ovf, unf
  );

  modport slave (
    input  we, wd, re,
    output wfull, rd, rvalid, rempty, usedw, ovf, unf
  );
endinterface

// File: rtl/fifo_dc_sync.sv
// fifo_dc_sync: single-clock synchronous FIFO, 2^N entries of W bits.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset, has priority over we/re
//   bus : fifo_dc_sync_if.slave carrying the write port (we, wd, wfull),
//         the read port (re, rd, rvalid, rempty) and status
//         (usedw, ovf, unf)
// Reads have one cycle of latency and there is no fall-through: a word
// written into an empty FIFO becomes readable on the following cycle.
module fifo_dc_sync #(
  parameter int W = 4,
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst,
  fifo_dc_sync_if.slave      bus
);

  localparam logic [N:0] ONE       = (N+1)'(1);
  localparam logic [N:0] ZERO      = '0;
  localparam logic [N:0] DEPTH_CNT = (N+1)'(1 << N);

  // Occupancy after one edge given which sides were accepted.
  function automatic logic [N:0] next_count(input logic [N:0] c,
                                            input logic w,
                                            input logic r);
    logic [N:0] res;
    res = c;
    case ({w, r})
      2'b10:   res = c + ONE;
      2'b01:   res = c - ONE;
      default: res = c;
    endcase
    return res;
  endfunction

  logic [W-1:0] mem [1 << N];

  // Pointers carry one extra MSB so a full FIFO and an empty FIFO
  // (same address bits) remain distinguishable after wrap.
  logic [N:0]   wptr;
  logic [N:0]   rptr;
  logic [N:0]   cnt_p1;
  logic         full_p1;
  logic         empty_p1;
  logic [W-1:0] rd_p1;
  logic         vld_p1;
  logic         ovf_p1;
  logic         unf_p1;

  logic         wacc;
  logic         racc;
  logic [N:0]   cnt_next;

  // Acceptance decisions use the registered flags, so a full FIFO
  // still accepts a simultaneous read and drops the write, and an empty
  // FIFO accepts a simultaneous write and rejects the read.
  assign wacc     = bus.we && !full_p1;
  assign racc     = bus.re && !empty_p1;
  assign cnt_next = next_count(cnt_p1, wacc, racc);

  // ---- stage p0 -> p1: pointers, occupancy, flags, read register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= ZERO;
      rptr     <= ZERO;
      cnt_p1   <= ZERO;
      full_p1  <= 1'b0;
      empty_p1 <= 1'b1;
      rd_p1    <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else begin
      if (wacc) begin
        wptr <= wptr + ONE;
      end
      if (racc) begin
        rptr  <= rptr + ONE;
        rd_p1 <= mem[rptr[N-1:0]];
      end
      vld_p1   <= racc;
      cnt_p1   <= cnt_next;
      full_p1  <= (cnt_next == DEPTH_CNT);
      empty_p1 <= (cnt_next == ZERO);
      ovf_p1   <= bus.we && full_p1;
      unf_p1   <= bus.re && empty_p1;
    end
  end

  // Storage is not cleared by reset; the reset pointers make old
  // contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wacc) begin
      mem[wptr[N-1:0]] <= bus.wd;
    end
  end

  assign bus.rd     = rd_p1;
  assign bus.rvalid = vld_p1;
  assign bus.wfull  = full_p1;
  assign bus.rempty = empty_p1;
  assign bus.usedw  = cnt_p1;
  assign bus.ovf    = ovf_p1;
  assign bus.unf    = unf_p1;

endmodule

// File: tb/tb_fifo_dc_sync.sv
module tb_fifo_dc_sync;
  localparam int W = 4;
  localparam int N = 2;
  localparam int DEPTH = 1 << N;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_dc_sync_if #(.W(W), .N(N)) bus ();

  fifo_dc_sync #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a queue of stored words plus the expected
  // registered outputs after each edge.
  logic [W-1:0] q[$];
  logic [W-1:0] e_rd;
  bit           e_rvalid;
  bit           e_ovf;
  bit           e_unf;
  int           e_used;
  bit           model_ok;

  initial model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e_rd     = '0;
      e_rvalid = 1'b0;
      e_ovf    = 1'b0;
      e_unf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit wa;
      bit ra;
      wa = bus.we && (q.size() < DEPTH);
      ra = bus.re && (q.size() > 0);
      e_ovf = bus.we && (q.size() == DEPTH);
      e_unf = bus.re && (q.size() == 0);
      e_rvalid = ra;
      if (ra) e_rd = q.pop_front();
      if (wa) q.push_back(bus.wd);
    end
    e_used = q.size();
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_usedw",  32'(bus.usedw),  32'(e_used));
      chk("m_rempty", 32'(bus.rempty), 32'(e_used == 0));
      chk("m_wfull",  32'(bus.wfull),  32'(e_used == DEPTH));
      chk("m_rvalid", 32'(bus.rvalid), 32'(e_rvalid));
      chk("m_rd",     32'(bus.rd),     32'(e_rd));
      chk("m_ovf",    32'(bus.ovf),    32'(e_ovf));
      chk("m_unf",    32'(bus.unf),    32'(e_unf));
    end
  end

  // Drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic step(input bit r, input bit w, input logic [W-1:0] d,
                      input bit rdq);
    rst    = r;
    bus.we = w;
    bus.wd = d;
    bus.re = rdq;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.we = 1'b0;
    bus.wd = '0;
    bus.re = 1'b0;

    // Reset held with random traffic.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      chk("rst_rempty", 32'(bus.rempty), 32'd1);
      chk("rst_usedw",  32'(bus.usedw),  32'd0);
      chk("rst_rd",     32'(bus.rd),     32'd0);
    end

    // Fill.
    step(1'b0, 1'b1, 4'b0001, 1'b0);
    chk("fill1_usedw",  32'(bus.usedw), 32'd1);
    chk("fill1_rempty", 32'(bus.rempty), 32'd0);
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    chk("fill2_usedw", 32'(bus.usedw), 32'd2);
    step(1'b0, 1'b1, 4'b0100, 1'b0);
    chk("fill3_usedw", 32'(bus.usedw), 32'd3);
    chk("fill3_wfull", 32'(bus.wfull), 32'd0);
    step(1'b0, 1'b1, 4'b1000, 1'b0);
    chk("fill4_usedw", 32'(bus.usedw), 32'd4);
    chk("fill4_wfull", 32'(bus.wfull), 32'd1);

    // Overflow.
    step(1'b0, 1'b1, 4'b1111, 1'b0);
    chk("ovf_pulse", 32'(bus.ovf),   32'd1);
    chk("ovf_usedw", 32'(bus.usedw), 32'd4);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    chk("ovf_clear", 32'(bus.ovf), 32'd0);

    // Drain.
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("drain1_rd",     32'(bus.rd),     32'h1);
    chk("drain1_rvalid", 32'(bus.rvalid), 32'd1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("drain2_rd", 32'(bus.rd), 32'h2);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("drain3_rd", 32'(bus.rd), 32'h4);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("drain4_rd",     32'(bus.rd),     32'h8);
    chk("drain4_rempty", 32'(bus.rempty), 32'd1);
    chk("drain4_usedw",  32'(bus.usedw),  32'd0);

    // Underflow; rd holds its last value.
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("unf_pulse",  32'(bus.unf),    32'd1);
    chk("unf_rvalid", 32'(bus.rvalid), 32'd0);
    chk("unf_rdhold", 32'(bus.rd),     32'h8);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    chk("unf_clear", 32'(bus.unf), 32'd0);

    // Simultaneous with 2 stored; pointers wrap across the 8 cycles.
    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    begin
      logic [W-1:0] exp_seq [8];
      exp_seq = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, 4'(6 + i), 1'b1);
        chk("sim_rd",    32'(bus.rd),    32'(exp_seq[i]));
        chk("sim_usedw", 32'(bus.usedw), 32'd2);
      end
    end
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("sim_tail1", 32'(bus.rd), 32'd12);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("sim_tail2", 32'(bus.rd), 32'd13);
    chk("sim_empty", 32'(bus.rempty), 32'd1);

    // we+re while empty: write only, read flags unf, no fall-through.
    step(1'b0, 1'b1, 4'hA, 1'b1);
    chk("e_sim_unf",    32'(bus.unf),    32'd1);
    chk("e_sim_rvalid", 32'(bus.rvalid), 32'd0);
    chk("e_sim_usedw",  32'(bus.usedw),  32'd1);

    // we+re while full: read only, write flags ovf.
    step(1'b0, 1'b1, 4'hB, 1'b0);
    step(1'b0, 1'b1, 4'hC, 1'b0);
    step(1'b0, 1'b1, 4'hD, 1'b0);
    step(1'b0, 1'b1, 4'hE, 1'b1);
    chk("f_sim_ovf",   32'(bus.ovf),   32'd1);
    chk("f_sim_rd",    32'(bus.rd),    32'hA);
    chk("f_sim_usedw", 32'(bus.usedw), 32'd3);

    // Reset mid-operation (with a write pending) discards contents.
    step(1'b1, 1'b1, 4'h6, 1'b0);
    chk("mrst_usedw",  32'(bus.usedw),  32'd0);
    chk("mrst_rempty", 32'(bus.rempty), 32'd1);
    step(1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("mrst_rd",     32'(bus.rd),     32'h9);
    chk("mrst_rvalid", 32'(bus.rvalid), 32'd1);

    step(1'b0, 1'b0, 4'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_dc_sync.md
# fifo_dc_sync

Single-clock synchronous FIFO with 2^N entries of W bits each. It provides a write port and a read port that share one clock. It buffers data between a producer and a consumer in the same clock domain. Full/empty flags, an occupancy count, and overflow/underflow indications let both sides throttle safely.

## Interface
Parameters:
- W, 4, data word width in bits (≥1)
- N, 2, log2 of depth; depth = 2^N entries (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset (sampled on rising edge of clk)
- we  in  1  write request
- wd  in  W  write data, sampled with we
- wfull  out  1  FIFO holds 2^N words; writes are ignored
- re  in  1  read request
- rd  out  W  read data, registered
- rvalid  out  1  rd holds the word popped by the previous cycle's accepted read
- rempty  out  1  FIFO holds 0 words; reads are ignored
- usedw  out  N+1  current occupancy, 0..2^N
- ovf  out  1  one-cycle pulse: we asserted while wfull
- unf  out  1  one-cycle pulse: re asserted while rempty

## Operation
- Storage: 2^N × W memory array plus N+1-bit write and read pointers; address = pointer[N-1:0]; MSB distinguishes full from empty on wrap.
- Write accepted iff we && !wfull: mem[wptr] <= wd, wptr <= wptr+1.
- Read accepted iff re && !rempty: rd <= mem[rptr], rptr <= rptr+1, rvalid <= 1; otherwise rvalid <= 0 and rd holds its last value.
- Flags are registered and derived from the next-state occupancy:
  - rempty = (usedw == 0)
  - wfull = (usedw == 2^N)
  - usedw <= usedw + write_acc − read_acc
- Simultaneous re and we:
  - empty: only the write is accepted; the read flags unf. There is no fall-through, so the data becomes readable next cycle.
  - full: only the read is accepted; the write flags ovf and is dropped.
  - otherwise: both are accepted and usedw is unchanged.
- Pointers wrap modulo 2^(N+1); address wrap-around is transparent to the user.
- Rejected writes and reads never modify memory, pointers or count.
- Data order is strictly first-in first-out.

## Timing
- Reset, when rst = 1 at a clk edge:
  - wptr = rptr = 0, usedw = 0, rempty = 1, wfull = 0
  - rd = 0, rvalid = 0, ovf = 0, unf = 0
  - memory contents are not cleared, but are unreachable after reset
- rst has priority over we/re in the same cycle. A reset mid-operation discards all stored words.
- Write-to-flag latency: 1 cycle. rempty falls on the edge that accepts the first write, and is visible the following cycle.
- Read latency: 1 cycle. The word appears on rd with rvalid = 1 in the cycle after the accepting edge.
- wfull rises on the edge accepting the 2^N-th outstanding write. rempty rises on the edge accepting the read of the last word.
- ovf and unf are single-cycle pulses registered on the offending edge, i.e. visible the next cycle.
- Back-to-back accepted reads and writes sustain one word per cycle each.

## Test plan
- Reset: hold rst = 1 for 10 cycles with random we/re -> rempty = 1, wfull = 0, usedw = 0, rvalid = 0, rd = 0 throughout.
- Fill (W = 4, N = 2): write 0001, 0010, 0100, 1000 on consecutive cycles -> usedw goes 1, 2, 3, 4; wfull = 1 after the 4th write; rempty = 0 after the 1st.
- Drain: then assert re for 4 cycles -> rd = 0001, 0010, 0100, 1000 with rvalid = 1, each one cycle after its read; rempty = 1 and usedw = 0 after the 4th read.
- Overflow/underflow: fifth write while full -> ovf pulse, usedw stays 4, later reads still return the original 4 words; read while empty -> unf pulse, rvalid = 0.
- Simultaneous: with 2 words stored, assert we and re together for 8 cycles -> usedw stays 2, output sequence is in order, and pointers wrap cleanly.
- Reset mid-operation: store 3 words, assert rst for 1 cycle -> usedw = 0, rempty = 1; the next write/read pair returns the new word, not stale data.
